// File: rtl/ccd_frame_sequencer_pkg.sv
// ccd_pkg: shared types and default timing for the CCD frame sequencer.
//   ccd_state_e  - sequencer FSM state encoding
//   DEF_*        - default timing constants (cycles of clk)
//   load_val()   - converts a phase length into a down-counter load value
package ccd_pkg;

  localparam int TMR_W = 24;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PGATE    = 3'd1,
    L1       = 3'd2,
    RST      = 3'd3,
    SIG      = 3'd4,
    WAIT_ACK = 3'd5,
    EXPOSE   = 3'd6
  } ccd_state_e;

  localparam int DEF_NPIX      = 2052;
  localparam int DEF_TP_CYC    = 400;
  localparam int DEF_TL1_CYC   = 390;
  localparam int DEF_TRST_CYC  = 195;
  localparam int DEF_TSIG_CYC  = 195;
  localparam int DEF_TEXP_BASE = 1000;
  localparam int DEF_TSTEP     = 100000;
  localparam int DEF_ACK_TO    = 1024;

  // The timer stays in a state until it reaches zero, so a length of N
  // loads N-1. Zero is promoted to one cycle; lengths beyond the counter
  // range saturate at the largest count.
  function automatic logic [TMR_W-1:0] load_val(input logic [39:0] len);
    if (len == 40'd0)
      return '0;
    else if (len > 40'h00_0100_0000)
      return '1;
    else
      return TMR_W'(len - 40'd1);
  endfunction

endpackage

// File: rtl/ccd_frame_sequencer_if.sv
// Sequencer-side bundle: run control, ADC handshake and CCD clock outputs.
//   master: run control (enable, f_select) and ADC side (sample_ack)
//   slave : the sequencer (drives phases, sample_req, pix_idx, status)
interface ccd_frame_sequencer_if;
  logic        enable;
  logic [3:0]  f_select;
  logic        sample_ack;
  logic        phi_p;
  logic        phi_l1;
  logic        phi_l2;
  logic        phi_r;
  logic        sample_req;
  logic [11:0] pix_idx;
  logic        busy;
  logic        frame_done;
  logic        ack_err;

  modport master (
    output enable, f_select, sample_ack,
    input  phi_p, phi_l1, phi_l2, phi_r, sample_req, pix_idx, busy, frame_done, ack_err
  );

  modport slave (
    input  enable, f_select, sample_ack,
    output phi_p, phi_l1, phi_l2, phi_r, sample_req, pix_idx, busy, frame_done, ack_err
  );
endinterface

// File: rtl/ccd_frame_sequencer_phase_timer.sv
// ccd_phase_timer: loadable down counter timing each sequencer state.
//   clk, rst  - clock, synchronous active-high reset
//   load      - load load_val this cycle (takes priority over counting)
//   load_val  - start count
//   done      - count has reached zero
module ccd_phase_timer
  import ccd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/ccd_frame_sequencer.sv
// ccd_frame_sequencer: CCD readout sequencer. Pulses the photogate, then for
// each pixel runs L1 / reset / signal phases and an ADC sample handshake,
// then waits out a selectable exposure before the next frame.
//   clk, rst - clock, synchronous active-high reset
//   bus      - ccd_frame_sequencer_if.slave (enable, f_select, sample_ack in;
//              phi_p/l1/l2/r, sample_req, pix_idx, busy, frame_done, ack_err out)
// Build option: CCD_SEQ_ACK_TIMEOUT_EN enables the sample-ack timeout and
// sticky ack_err; without it WAIT_ACK waits forever and ack_err is 0.
//
// state    | meaning
// IDLE     | stopped, all outputs low
// PGATE    | photogate pulse (phi_p, phi_r, phi_l2)
// L1       | transfer to output node (phi_l1)
// RST      | output node reset (phi_r, phi_l2)
// SIG      | signal settle (phi_l2)
// WAIT_ACK | ADC convert request until sample_ack
// EXPOSE   | integration wait, all phases low
module ccd_frame_sequencer
  import ccd_pkg::*;
#(
  parameter int NPIX      = DEF_NPIX,
  parameter int TP_CYC    = DEF_TP_CYC,
  parameter int TL1_CYC   = DEF_TL1_CYC,
  parameter int TRST_CYC  = DEF_TRST_CYC,
  parameter int TSIG_CYC  = DEF_TSIG_CYC,
  parameter int TEXP_BASE = DEF_TEXP_BASE,
  parameter int TSTEP     = DEF_TSTEP,
  parameter int ACK_TO    = DEF_ACK_TO
) (
  input logic                  clk,
  input logic                  rst,
  ccd_frame_sequencer_if.slave bus
);

  localparam logic [TMR_W-1:0] LD_TP   = load_val(40'(TP_CYC));
  localparam logic [TMR_W-1:0] LD_TL1  = load_val(40'(TL1_CYC));
  localparam logic [TMR_W-1:0] LD_TRST = load_val(40'(TRST_CYC));
  localparam logic [TMR_W-1:0] LD_TSIG = load_val(40'(TSIG_CYC));
  localparam logic [TMR_W-1:0] LD_ACK  = load_val(40'(ACK_TO));
  localparam logic [11:0]      LAST_PIX = (NPIX <= 1) ? 12'd0 : 12'(NPIX - 1);

  ccd_state_e       state_q, state_d;
  logic [3:0]       fsel_q, fsel_d;
  logic [11:0]      pix_q, pix_d;
  logic             phi_p_q, phi_p_d, phi_l1_q, phi_l1_d;
  logic             phi_l2_q, phi_l2_d, phi_r_q, phi_r_d;
  logic             req_q, req_d, busy_q, busy_d, fd_q, fd_d;
  logic             adv;
  logic             tmr_load, tmr_done;
  logic [TMR_W-1:0] tmr_ld_val;
  logic [39:0]      exp_len;
`ifdef CCD_SEQ_ACK_TIMEOUT_EN
  logic             err_q, err_d;
`endif

  ccd_phase_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_ld_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    fsel_d  = fsel_q;
    pix_d   = pix_q;
    adv     = 1'b0;
`ifdef CCD_SEQ_ACK_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          fsel_d  = bus.f_select;
          pix_d   = '0;
          state_d = PGATE;
        end
      end
      PGATE:    if (tmr_done) state_d = L1;
      L1:       if (tmr_done) state_d = RST;
      RST:      if (tmr_done) state_d = SIG;
      SIG:      if (tmr_done) state_d = WAIT_ACK;
      WAIT_ACK: begin
        adv = bus.sample_ack;
`ifdef CCD_SEQ_ACK_TIMEOUT_EN
        if (!bus.sample_ack && tmr_done) begin
          adv   = 1'b1;
          err_d = 1'b1;
        end
`endif
        if (adv) begin
          // The last pixel always finishes the frame; an enable drop only
          // aborts at an earlier pixel boundary.
          if (pix_q == LAST_PIX) begin
            state_d = EXPOSE;
          end else if (!bus.enable) begin
            pix_d   = '0;
            state_d = IDLE;
          end else begin
            pix_d   = pix_q + 12'd1;
            state_d = L1;
          end
        end
      end
      EXPOSE: begin
        if (tmr_done) begin
          pix_d = '0;
          if (bus.enable) begin
            fsel_d  = bus.f_select;
            state_d = PGATE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    exp_len = 40'(TEXP_BASE) + 40'(fsel_d) * 40'(TSTEP);

    tmr_load = (state_d != state_q);
    case (state_d)
      PGATE:    tmr_ld_val = LD_TP;
      L1:       tmr_ld_val = LD_TL1;
      RST:      tmr_ld_val = LD_TRST;
      SIG:      tmr_ld_val = LD_TSIG;
      WAIT_ACK: tmr_ld_val = LD_ACK;
      EXPOSE:   tmr_ld_val = load_val(exp_len);
      default:  tmr_ld_val = '0;
    endcase

    // Outputs are decoded from the next state so they line up with state_q.
    phi_p_d  = (state_d == PGATE);
    phi_l1_d = (state_d == L1);
    phi_r_d  = (state_d == PGATE) || (state_d == RST);
    phi_l2_d = (state_d == PGATE) || (state_d == RST) ||
               (state_d == SIG)   || (state_d == WAIT_ACK);
    req_d    = (state_d == WAIT_ACK);
    busy_d   = (state_d != IDLE);
    fd_d     = (state_q == WAIT_ACK) && (state_d == EXPOSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      fsel_q   <= '0;
      pix_q    <= '0;
      phi_p_q  <= 1'b0;
      phi_l1_q <= 1'b0;
      phi_l2_q <= 1'b0;
      phi_r_q  <= 1'b0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      fd_q     <= 1'b0;
`ifdef CCD_SEQ_ACK_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      fsel_q   <= fsel_d;
      pix_q    <= pix_d;
      phi_p_q  <= phi_p_d;
      phi_l1_q <= phi_l1_d;
      phi_l2_q <= phi_l2_d;
      phi_r_q  <= phi_r_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      fd_q     <= fd_d;
`ifdef CCD_SEQ_ACK_TIMEOUT_EN
      err_q    <= err_d;
`endif
    end
  end

  assign bus.phi_p      = phi_p_q;
  assign bus.phi_l1     = phi_l1_q;
  assign bus.phi_l2     = phi_l2_q;
  assign bus.phi_r      = phi_r_q;
  assign bus.sample_req = req_q;
  assign bus.pix_idx    = pix_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = fd_q;
`ifdef CCD_SEQ_ACK_TIMEOUT_EN
  assign bus.ack_err    = err_q;
`else
  assign bus.ack_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ccd_frame_sequencer.sv
// Testbench for ccd_frame_sequencer with NPIX=4, TP=3, TL1=4, TRST=2, TSIG=2,
// TEXP_BASE=10, TSTEP=5, ACK_TO=8. Output activity is cut into segments of
// constant pattern; expected segments are queued before each run and checked
// as each segment ends.
`timescale 1ns/1ps
module tb_ccd_frame_sequencer;

  localparam logic [5:0] PH_PG = 6'b110110; // busy,p,l1,l2,r,req
  localparam logic [5:0] PH_L1 = 6'b101000;
  localparam logic [5:0] PH_RS = 6'b100110;
  localparam logic [5:0] PH_SG = 6'b100100;
  localparam logic [5:0] PH_WA = 6'b100101;
  localparam logic [5:0] PH_EX = 6'b100000;

  typedef struct {
    logic [18:0] pat;
    int          len;
  } seg_t;

  typedef struct {
    logic [3:0] fsel;
    bit         stray;
    int         exp_len;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   ack_mode = 1;   // 0 withhold, 1 answer req, 2 held high
  bit   mon_en = 0, mon_first = 0, mon_skip = 0;
  logic [18:0] cur_pat, mon_p;
  int   cur_len = 0;
  int   fd_cnt = 0;
  seg_t exp_q[$];
  vec_t vtab[4];

  always #5 clk = ~clk;

  ccd_frame_sequencer_if sif ();

  ccd_frame_sequencer #(
    .NPIX(4), .TP_CYC(3), .TL1_CYC(4), .TRST_CYC(2), .TSIG_CYC(2),
    .TEXP_BASE(10), .TSTEP(5), .ACK_TO(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  always @(negedge clk) begin
    case (ack_mode)
      0:       sif.sample_ack = 1'b0;
      1:       sif.sample_ack = sif.sample_req;
      default: sif.sample_ack = 1'b1;
    endcase
  end

  function automatic logic [18:0] cur_pat_f();
    logic [5:0] ph;
    ph = {sif.busy, sif.phi_p, sif.phi_l1, sif.phi_l2, sif.phi_r, sif.sample_req};
    return {ph, sif.frame_done, (ph == PH_EX) ? 12'd0 : sif.pix_idx};
  endfunction

  task automatic check_seg(input logic [18:0] pat, input int len);
    seg_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL seg_extra: got pat=%05h len=%0d, required no further segment", pat, len);
    end else begin
      e = exp_q.pop_front();
      if (pat !== e.pat || len != e.len) begin
        n_err++;
        $display("FAIL seg: got pat=%05h len=%0d, required pat=%05h len=%0d",
                 pat, len, e.pat, e.len);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_p = cur_pat_f();
      if (sif.frame_done === 1'b1) fd_cnt++;
      if (mon_first) begin
        cur_pat   = mon_p;
        cur_len   = 1;
        mon_first = 0;
        mon_skip  = 1;
      end else if (mon_p === cur_pat) begin
        cur_len++;
      end else begin
        if (mon_skip) mon_skip = 0;
        else check_seg(cur_pat, cur_len);
        cur_pat = mon_p;
        cur_len = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  task automatic push(input logic [5:0] ph, input logic fd, input int pix, input int len);
    seg_t s;
    s.pat = {ph, fd, 12'(pix)};
    s.len = len;
    exp_q.push_back(s);
  endtask

  task automatic push_pixel(input int k);
    push(PH_L1, 1'b0, k, 4);
    push(PH_RS, 1'b0, k, 2);
    push(PH_SG, 1'b0, k, 2);
    push(PH_WA, 1'b0, k, 1);
  endtask

  task automatic push_frame(input int exp_len);
    push(PH_PG, 1'b0, 0, 3);
    for (int k = 0; k < 4; k++) push_pixel(k);
    push(PH_EX, 1'b1, 0, 1);
    push(PH_EX, 1'b0, 0, exp_len - 1);
  endtask

  task automatic mon_start();
    fd_cnt    = 0;
    mon_first = 1;
    mon_en    = 1;
  endtask

  task automatic wait_fd(input string nm);
    int i;
    for (i = 0; i < 400; i++) begin
      tick();
      if (sif.frame_done === 1'b1) break;
    end
    chk(nm, 32'(i < 400), 32'd1);
  endtask

  task automatic wait_pix1(input string nm);
    int i;
    for (i = 0; i < 200; i++) begin
      tick();
      if (sif.pix_idx === 12'd1 && sif.phi_l1 === 1'b1) break;
    end
    chk(nm, 32'(i < 200), 32'd1);
  endtask

  task automatic wait_req(input string nm);
    int i;
    for (i = 0; i < 200; i++) begin
      tick();
      if (sif.sample_req === 1'b1) break;
    end
    chk(nm, 32'(i < 200), 32'd1);
  endtask

  task automatic wait_drain(input string nm);
    int i;
    for (i = 0; i < 500; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    mon_en = 0;
  endtask

  function automatic logic [31:0] outs();
    return {22'd0, sif.phi_p, sif.phi_l1, sif.phi_l2, sif.phi_r,
            sif.sample_req, sif.busy, sif.frame_done, sif.ack_err, 2'd0};
  endfunction

  initial begin
    int n;
    vtab[0] = '{4'd2,  1'b0, 20};
    vtab[1] = '{4'd0,  1'b1, 10};
    vtab[2] = '{4'd7,  1'b0, 45};
    vtab[3] = '{4'd15, 1'b1, 85};

    rst = 1'b1;
    sif.enable   = 1'b0;
    sif.f_select = 4'd0;
    repeat (3) tick();
    chk("reset_outs", outs(), 32'd0);
    chk("reset_pix", 32'(sif.pix_idx), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_outs", outs(), 32'd0);

    // Single frames from IDLE, one per table entry; stray entries hold
    // sample_ack high throughout, which must not disturb the sequence.
    for (int v = 0; v < 4; v++) begin
      mon_start();
      ack_mode     = vtab[v].stray ? 2 : 1;
      sif.f_select = vtab[v].fsel;
      sif.enable   = 1'b1;
      push_frame(vtab[v].exp_len);
      wait_fd("frame_done_seen");
      sif.enable   = 1'b0;
      sif.f_select = 4'd9;
      wait_drain("frame_segments");
      chk("frame_done_count", 32'(fd_cnt), 32'd1);
      tick();
      chk("back_idle", outs(), 32'd0);
      ack_mode = 1;
    end

    // Back-to-back frames: f_select changed mid-frame only takes effect at
    // the next frame, and changing it during that frame has no effect either.
    mon_start();
    sif.f_select = 4'd0;
    sif.enable   = 1'b1;
    push_frame(10);
    push_frame(85);
    wait_pix1("pix1_frame1");
    sif.f_select = 4'd15;
    wait_fd("fd_frame1");
    wait_pix1("pix1_frame2");
    sif.f_select = 4'd3;
    wait_fd("fd_frame2");
    sif.enable = 1'b0;
    wait_drain("repeat_segments");
    chk("repeat_fd_count", 32'(fd_cnt), 32'd2);

    // Abort: enable dropped during pixel 1.
    repeat (2) tick();
    mon_start();
    sif.f_select = 4'd0;
    sif.enable   = 1'b1;
    push(PH_PG, 1'b0, 0, 3);
    push_pixel(0);
    push_pixel(1);
    wait_pix1("abort_pix1");
    sif.enable = 1'b0;
    wait_drain("abort_segments");
    repeat (5) tick();
    chk("abort_outs", outs(), 32'd0);
    chk("abort_pix", 32'(sif.pix_idx), 32'd0);
    chk("abort_no_fd", 32'(fd_cnt), 32'd0);

    // Reset while a sample request is pending.
    ack_mode     = 0;
    sif.f_select = 4'd1;
    sif.enable   = 1'b1;
    wait_req("rst_req_seen");
    rst = 1'b1;
    sif.enable = 1'b0;
    tick();
    chk("rst_mid_outs", outs(), 32'd0);
    chk("rst_mid_pix", 32'(sif.pix_idx), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_mid_idle", outs(), 32'd0);

    // Withheld acknowledge.
    sif.f_select = 4'd0;
    sif.enable   = 1'b1;
    wait_req("to_req_seen");
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sif.sample_req === 1'b1) n++;
      else break;
    end
`ifdef CCD_SEQ_ACK_TIMEOUT_EN
    chk("to_req_cycles", 32'(n), 32'd8);
    chk("to_ack_err", 32'(sif.ack_err), 32'd1);
    chk("to_next_pix", 32'(sif.pix_idx), 32'd1);
    ack_mode = 1;
    repeat (20) tick();
    chk("to_ack_err_sticky", 32'(sif.ack_err), 32'd1);
`else
    chk("stall_req_cycles", 32'(n), 32'd41);
    chk("stall_ack_err", 32'(sif.ack_err), 32'd0);
    chk("stall_pix", 32'(sif.pix_idx), 32'd0);
`endif
    sif.enable = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ack_mode = 1;
    tick();
    chk("post_rst_ack_err", 32'(sif.ack_err), 32'd0);
    chk("post_rst_outs", outs(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
